// File: rtl/alu_issue_fifo.sv
// Issue FIFO between instruction decode and the ALU: DEPTH-entry ring buffer with
// registered issue outputs. Optional 16-bit pop counter under `ALU_ISSUE_STATS_EN.
module alu_issue_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       IN_VLD,
  output logic                       IN_RDY,
  input  logic [3:0]                 IN_OP,
  input  logic [1:0]                 IN_MOVI,
  input  logic [DATA_WIDTH-1:0]      IN_REG_A,
  input  logic [DATA_WIDTH-1:0]      IN_REG_B,
  input  logic [DATA_WIDTH-1:0]      IN_IMM,
  input  logic [DATA_WIDTH-1:0]      IN_MEM,
  input  logic                       ALU_RDY,
  output logic                       ACT,
  output logic [3:0]                 OP,
  output logic [1:0]                 MOVI,
  output logic [DATA_WIDTH-1:0]      REG_A,
  output logic [DATA_WIDTH-1:0]      REG_B,
  output logic [DATA_WIDTH-1:0]      IMM,
  output logic [DATA_WIDTH-1:0]      MEM,
  output logic [$clog2(DEPTH):0]     COUNT
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]                ISSUE_CNT
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("alu_issue_fifo: DEPTH must be a power of 2 and at least 2");
  end

  typedef struct packed {
    logic [3:0]            op;
    logic [1:0]            movi;
    logic [DATA_WIDTH-1:0] reg_a;
    logic [DATA_WIDTH-1:0] reg_b;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] mem;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          in_ent;
  entry_t          out_q, out_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            act_q, act_d;
  logic            push, pop;

  assign in_ent = '{op: IN_OP, movi: IN_MOVI, reg_a: IN_REG_A,
                    reg_b: IN_REG_B, imm: IN_IMM, mem: IN_MEM};

  // Both handshakes look only at registered occupancy, so a full FIFO stays
  // closed for the cycle of a pop and an empty one cannot bypass to the ALU.
  assign push = IN_VLD && (count_q != CW'(DEPTH));
  assign pop  = ALU_RDY && (count_q != '0);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    out_d   = out_q;
    act_d   = 1'b0;
    if (pop) begin
      out_d  = mem_q[head_q];
      act_d  = 1'b1;
      head_d = head_q + PW'(1);
    end
    if (push) tail_d = tail_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      act_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      act_q   <= act_d;
      out_q   <= out_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge CLK) begin
    if (push) mem_q[tail_q] <= in_ent;
  end

  assign IN_RDY = (count_q != CW'(DEPTH));
  assign COUNT  = count_q;
  assign ACT    = act_q;
  assign OP     = out_q.op;
  assign MOVI   = out_q.movi;
  assign REG_A  = out_q.reg_a;
  assign REG_B  = out_q.reg_b;
  assign IMM    = out_q.imm;
  assign MEM    = out_q.mem;

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] issue_cnt_q, issue_cnt_d;

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    if (pop) issue_cnt_d = issue_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) issue_cnt_q <= '0;
    else      issue_cnt_q <= issue_cnt_d;
  end

  assign ISSUE_CNT = issue_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_fifo.sv
// Randomized + directed bench for alu_issue_fifo against a queue-based model.
module tb_alu_issue_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [3:0]    op;
    logic [1:0]    movi;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] imm;
    logic [DW-1:0] mem;
  } ent_t;

  logic          CLK = 1'b0, RST = 1'b0, IN_VLD = 1'b0, ALU_RDY = 1'b0;
  logic [3:0]    IN_OP = '0;
  logic [1:0]    IN_MOVI = '0;
  logic [DW-1:0] IN_REG_A = '0, IN_REG_B = '0, IN_IMM = '0, IN_MEM = '0;
  logic          IN_RDY, ACT;
  logic [3:0]    OP;
  logic [1:0]    MOVI;
  logic [DW-1:0] REG_A, REG_B, IMM, MEM;
  logic [CW-1:0] COUNT;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0]   ISSUE_CNT;
`endif

  alu_issue_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .IN_VLD(IN_VLD), .IN_RDY(IN_RDY),
    .IN_OP(IN_OP), .IN_MOVI(IN_MOVI), .IN_REG_A(IN_REG_A), .IN_REG_B(IN_REG_B),
    .IN_IMM(IN_IMM), .IN_MEM(IN_MEM), .ALU_RDY(ALU_RDY), .ACT(ACT),
    .OP(OP), .MOVI(MOVI), .REG_A(REG_A), .REG_B(REG_B), .IMM(IMM), .MEM(MEM),
    .COUNT(COUNT)
`ifdef ALU_ISSUE_STATS_EN
    , .ISSUE_CNT(ISSUE_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  ent_t        q[$];
  ent_t        exp_out   = '0;
  bit          exp_act   = 1'b0;
  logic [15:0] exp_issue = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic ent_t dut_ent();
    return '{OP, MOVI, REG_A, REG_B, IMM, MEM};
  endfunction

  function automatic ent_t in_ent();
    return '{IN_OP, IN_MOVI, IN_REG_A, IN_REG_B, IN_IMM, IN_MEM};
  endfunction

  // Reference: a plain queue, popped into the issue slot when non-empty and ALU ready.
  always @(posedge CLK or negedge RST) begin
    bit pu, po;
    if (!RST) begin
      q.delete();
      exp_act   = 1'b0;
      exp_out   = '0;
      exp_issue = '0;
    end else begin
      po = (q.size() != 0) && ALU_RDY;
      pu = IN_VLD && (q.size() != DEPTH);
      exp_act = po;
      if (po) begin
        exp_out = q.pop_front();
        exp_issue++;
      end
      if (pu) q.push_back(in_ent());
    end
  end

  always @(negedge CLK) begin
    chk("act", ACT, exp_act);
    chk("count", COUNT, q.size());
    chk("in_rdy", IN_RDY, q.size() != DEPTH);
    chk("fields", dut_ent(), exp_out);
`ifdef ALU_ISSUE_STATS_EN
    chk("issue_cnt", ISSUE_CNT, exp_issue);
`endif
  end

  task automatic cyc();
    @(negedge CLK);
    #1;
  endtask

  task automatic set_in(input bit v, input logic [3:0] op, input logic [1:0] mv,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] imm, input logic [7:0] mem);
    IN_VLD = v; IN_OP = op; IN_MOVI = mv;
    IN_REG_A = a; IN_REG_B = b; IN_IMM = imm; IN_MEM = mem;
  endtask

  task automatic set_rand(input bit v);
    set_in(v, 4'($urandom), 2'($urandom), 8'($urandom), 8'($urandom),
           8'($urandom), 8'($urandom));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    bit hit;
    // Reset state
    #1;
    chk("rst_count", COUNT, 0);
    chk("rst_act", ACT, 0);
    chk("rst_in_rdy", IN_RDY, 1);
    chk("rst_op", OP, 0);
    chk("rst_reg_a", REG_A, 0);
    cyc(); cyc();
    RST = 1'b1;

    // Single instruction: push at edge 1, issued in the cycle after edge 2
    ALU_RDY = 1'b1;
    set_in(1, 4'h3, 2'd0, 8'h12, 8'h34, 8'h00, 8'h00);
    cyc();
    IN_VLD = 1'b0;
    chk("single_act_early", ACT, 0);
    cyc();
    chk("single_act", ACT, 1);
    chk("single_op", OP, 4'h3);
    chk("single_reg_a", REG_A, 8'h12);
    chk("single_reg_b", REG_B, 8'h34);
    cyc();
    chk("single_act_off", ACT, 0);
    chk("single_op_hold", OP, 4'h3);

    // Fill past full with ALU stalled, then drain in order
    ALU_RDY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_in(1, 4'(i), 2'(i), 8'(8'h40 + i), 8'(i), 8'(i), 8'(i));
      cyc();
    end
    IN_VLD = 1'b0;
    chk("full_count", COUNT, 4);
    chk("full_in_rdy", IN_RDY, 0);
    ALU_RDY = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (ACT) begin
        chk("full_drain_order", REG_A, 8'(8'h40 + pulses));
        pulses++;
      end
    end
    chk("full_pulses", pulses, 4);
    chk("full_in_rdy_back", IN_RDY, 1);

    // Simultaneous push/pop at COUNT=2 across pointer wrap
    ALU_RDY = 1'b0;
    for (int i = 0; i < 2; i++) begin set_rand(1); cyc(); end
    chk("pp_count_pre", COUNT, 2);
    ALU_RDY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_rand(1);
      cyc();
      chk("pp_count", COUNT, 2);
    end
    IN_VLD = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    chk("pp_drained", COUNT, 0);

    // Asynchronous reset between edges at COUNT=3
    ALU_RDY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(1, 4'hC, 2'd3, 8'(8'h60 + i), 8'hEE, 8'hDD, 8'hCC);
      cyc();
    end
    IN_VLD = 1'b0;
    ALU_RDY = 1'b1;
    cyc();
    ALU_RDY = 1'b0;
    chk("rst_mid_count_pre", COUNT, 3);
    chk("rst_mid_act_pre", ACT, 1);
    #2 RST = 1'b0;
    #1;
    chk("rst_mid_count", COUNT, 0);
    chk("rst_mid_act", ACT, 0);
    chk("rst_mid_op", OP, 0);
    chk("rst_mid_reg_a", REG_A, 0);
    chk("rst_mid_in_rdy", IN_RDY, 1);
    cyc();
    RST = 1'b1;
    ALU_RDY = 1'b1;
    set_in(1, 4'hA, 2'd1, 8'h5A, 8'h5B, 8'h5C, 8'h5D);
    cyc();
    IN_VLD = 1'b0;
    cyc();
    chk("rst_rel_act", ACT, 1);
    chk("rst_rel_reg_a", REG_A, 8'h5A);
    cyc();
    chk("rst_rel_no_stale", ACT, 0);
    chk("rst_rel_count", COUNT, 0);

    // ALU_RDY toggling 1,0,1,0 with three entries queued
    ALU_RDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 4'(i + 5), 2'd2, 8'(8'h70 + i), 8'h01, 8'h02, 8'h03);
      cyc();
    end
    IN_VLD = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ALU_RDY = (i % 2 == 0);
      cyc();
      chk("tog_act", ACT, (i % 2 == 0));
      chk("tog_reg_a", REG_A, 8'(8'h70 + i / 2));
    end
    ALU_RDY = 1'b1;
    cyc(); cyc();

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      ALU_RDY = ($urandom_range(0, 9) < 7);
      set_rand($urandom_range(0, 1) == 1);
      cyc();
    end
    IN_VLD = 1'b0;
    ALU_RDY = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    chk("rand_drained", COUNT, 0);

`ifdef ALU_ISSUE_STATS_EN
    // Pop counter wrap
    hit = 1'b0;
    ALU_RDY = 1'b1;
    for (int i = 0; i < 70000 && !hit; i++) begin
      set_rand(1);
      cyc();
      if (exp_issue == 16'hFFFF) hit = 1'b1;
    end
    if (!hit) begin
      bad++;
      total++;
      $display("FAIL stats_budget: got no wrap point want 65535 pops within budget");
    end else begin
      chk("stats_max", ISSUE_CNT, 16'hFFFF);
      cyc();
      chk("stats_wrap", ISSUE_CNT, 16'h0000);
    end
    IN_VLD = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
`else
    hit = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_fifo.md
ALU_ISSUE_FIFO -- requirements
Module: alu_issue_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of REG_A, REG_B, IMM and MEM operands (from sv_alu_param_pkg).
REQ-002 Parameter DEPTH, default 4: number of buffered instructions; SHALL be a power of 2, at least 2.
REQ-003 CLK  input  1: single clock; all state SHALL be updated on its rising edge.
REQ-004 RST  input  1: asynchronous, active-low reset.
REQ-005 IN_VLD  input  1: upstream instruction valid.
REQ-006 IN_RDY  output  1: the FIFO can accept an instruction.
REQ-007 IN_OP  input  4; IN_MOVI  input  2: upstream operation and second-operand type.
REQ-008 IN_REG_A, IN_REG_B, IN_IMM, IN_MEM  input  DATA_WIDTH each: upstream operands.
REQ-009 ALU_RDY  input  1: the ALU accepts an instruction in this cycle.
REQ-010 ACT  output  1: an instruction is presented to the ALU.
REQ-011 OP  output  4; MOVI  output  2; REG_A, REG_B, IMM, MEM  output  DATA_WIDTH each: issued instruction fields, all registered.
REQ-012 COUNT  output  $clog2(DEPTH)+1: number of occupied FIFO entries.

Function
REQ-013 Push: on a rising edge where IN_VLD=1 and IN_RDY=1, the block SHALL write all IN_* fields into the tail entry.
REQ-014 IN_RDY SHALL equal (COUNT != DEPTH) and SHALL be derived from registered state only; a pop in the same cycle does not raise IN_RDY.
REQ-015 Pop/issue: on a rising edge where COUNT != 0 and ALU_RDY=1, the head entry SHALL be loaded into the output registers, ACT SHALL be set to 1 for the following cycle, and the head SHALL advance.
REQ-016 On any edge without a pop, ACT SHALL be set to 0 and OP, MOVI and the operand outputs SHALL hold their previous values.
REQ-017 There is no bypass: an instruction pushed at edge N SHALL produce ACT=1 no earlier than the cycle after edge N+1.
REQ-018 When a push and a pop occur on the same edge, COUNT SHALL stay unchanged and both operations SHALL take effect.
REQ-019 Head and tail pointers SHALL wrap modulo DEPTH; instruction order SHALL be strictly FIFO.
REQ-020 When ALU_RDY=0, no pop SHALL occur, and ACT SHALL be 0 in the next cycle.
REQ-021 When the FIFO is empty (COUNT=0), ALU_RDY SHALL be ignored and ACT SHALL be 0 in the next cycle.

Reset
REQ-022 While RST=0, without regard to CLK: COUNT=0, both pointers=0, ACT=0, OP=0, MOVI=0, REG_A=REG_B=IMM=MEM=0, IN_RDY=1.
REQ-023 A reset asserted mid-operation SHALL discard all buffered entries; an instruction presented in the reset-release cycle SHALL be accepted normally.

Configuration
REQ-024 Macro ALU_ISSUE_STATS_EN: when defined, the block SHALL add output ISSUE_CNT (16 bits, reset 0), incremented on every pop, wrapping from 0xFFFF to 0.
REQ-025 When ALU_ISSUE_STATS_EN is undefined, the ISSUE_CNT port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-026 Bench SHALL cover: with ALU_RDY=1, push OP=4'h3, REG_A=8'h12, REG_B=8'h34 at edge 1 -> ACT=1 with OP=3, REG_A=12, REG_B=34 in the cycle after edge 2, then ACT=0.
REQ-027 Bench SHALL cover: with ALU_RDY=0, push 5 entries into DEPTH=4 -> 4 accepted, IN_RDY=0, COUNT=4, fifth held off; raise ALU_RDY -> 4 ACT pulses in push order, IN_RDY returns to 1.
REQ-028 Bench SHALL cover: at COUNT=2, push and pop on the same edge -> COUNT stays 2; order preserved across pointer wrap after 10 sustained transfers.
REQ-029 Bench SHALL cover: RST driven low between edges at COUNT=3 -> immediate COUNT=0, ACT=0, outputs 0; no stale entry is issued after release.
REQ-030 Bench SHALL cover: ALU_RDY toggling 1,0,1,0 with 3 entries queued -> ACT pulses only after the ALU_RDY=1 edges, with operand outputs held between pulses.
REQ-031 Bench SHALL cover (ALU_ISSUE_STATS_EN defined): ISSUE_CNT preloaded by 65535 pops, one more pop -> ISSUE_CNT=0.
